// File: rtl/fm_demod_prep.sv
// fm_demod_prep
//   Front end of the FM discriminator. It takes the decimated I/Q streams,
//   keeps the previous sample, and forms cur * conj(prev). The real part (x)
//   and the imaginary part (y) go to the arctangent stage as a pair.
//
//   Each sample runs through three FSM phases: READ, SUM, WRITE. READ pops I
//   and Q together and registers the four cross products. SUM scales the
//   products down and combines them. WRITE pushes x and y together. The block
//   therefore accepts at most one sample every three cycles.
//
// Ports
//   clock, reset            single clock; synchronous active-high reset
//   real_rd_en/real_empty   I input FIFO handshake, real_dout = current I
//   imag_rd_en/imag_empty   Q input FIFO handshake, imag_dout = current Q
//   y_wr_en/y_full/y_din    imaginary-part output FIFO (arctan y input)
//   x_wr_en/x_full/x_din    real-part output FIFO (arctan x input)
//
// Build option
//   FM_DEMOD_SKIP_FIRST_EN  When defined, the first sample after reset only
//                           primes prev_r/prev_i and produces no output. This
//                           suppresses the meaningless result against prev=0.
module fm_demod_prep #(
  parameter int DATA_W     = 32,
  parameter int QUANT_BITS = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     real_rd_en,
  input  logic                     real_empty,
  input  logic signed [DATA_W-1:0] real_dout,
  output logic                     imag_rd_en,
  input  logic                     imag_empty,
  input  logic signed [DATA_W-1:0] imag_dout,
  output logic                     y_wr_en,
  input  logic                     y_full,
  output logic signed [DATA_W-1:0] y_din,
  output logic                     x_wr_en,
  input  logic                     x_full,
  output logic signed [DATA_W-1:0] x_din
);

  localparam int PROD_W = 2 * DATA_W;
  // Added to negative values before the arithmetic shift, so the shift
  // rounds toward zero the way a true divide does.
  localparam logic signed [PROD_W-1:0] QBIAS =
    (PROD_W'(1) <<< QUANT_BITS) - PROD_W'(1);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_SUM   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state, state_next;
  logic   pop, push;

  logic signed [DATA_W-1:0] prev_r, prev_i, neg_prev_i;
  logic signed [PROD_W-1:0] pr_p0, pi_p0, qr_p0, qi_p0;
  logic signed [DATA_W-1:0] x_reg_p1, y_reg_p1;
`ifdef FM_DEMOD_SKIP_FIRST_EN
  logic primed;
`endif

  // Full-width signed product. Both operands are sign-extended first, so
  // the 64-bit result is exact for every pair of 32-bit inputs.
  function automatic logic signed [PROD_W-1:0] widen_mul(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PROD_W-1:0] wa, wb;
    wa = PROD_W'(a);
    wb = PROD_W'(b);
    return wa * wb;
  endfunction

  // Signed divide by 2^QUANT_BITS, truncating toward zero. Only the low
  // DATA_W bits are kept.
  function automatic logic signed [DATA_W-1:0] dequantize(
    input logic signed [PROD_W-1:0] v
  );
    logic signed [PROD_W-1:0] biased, scaled;
    biased = (v < 0) ? v + QBIAS : v;
    scaled = biased >>> QUANT_BITS;
    return scaled[DATA_W-1:0];
  endfunction

  // Negate in DATA_W bits before widening. This makes -(-2^31) wrap back to
  // -2^31.
  assign neg_prev_i = -prev_i;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    push       = 1'b0;
    case (state)
      S_READ: begin
        // Pop only when both FIFOs can give a sample, so I and Q never skew.
        if (!real_empty && !imag_empty) begin
          pop        = 1'b1;
          state_next = S_SUM;
        end
      end
      S_SUM: begin
`ifdef FM_DEMOD_SKIP_FIRST_EN
        state_next = primed ? S_WRITE : S_READ;
`else
        state_next = S_WRITE;
`endif
      end
      S_WRITE: begin
        // x and y must be written as a pair. A full on either side stalls both.
        if (!x_full && !y_full) begin
          push       = 1'b1;
          state_next = S_READ;
        end
      end
      default: state_next = S_READ;
    endcase
    // A reset cycle must not pop or write, whatever state it interrupts.
    if (reset) begin
      pop  = 1'b0;
      push = 1'b0;
    end
  end

  assign real_rd_en = pop;
  assign imag_rd_en = pop;
  assign x_wr_en    = push;
  assign y_wr_en    = push;
  assign x_din      = push ? x_reg_p1 : '0;
  assign y_din      = push ? y_reg_p1 : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_READ;
      prev_r   <= '0;
      prev_i   <= '0;
      pr_p0    <= '0;
      pi_p0    <= '0;
      qr_p0    <= '0;
      qi_p0    <= '0;
      x_reg_p1 <= '0;
      y_reg_p1 <= '0;
`ifdef FM_DEMOD_SKIP_FIRST_EN
      primed   <= 1'b0;
`endif
    end else begin
      state <= state_next;

      // p0: cross products of the popped sample with conj(prev)
      if (pop) begin
        pr_p0  <= widen_mul(prev_r, real_dout);
        pi_p0  <= widen_mul(prev_r, imag_dout);
        qr_p0  <= widen_mul(neg_prev_i, real_dout);
        qi_p0  <= widen_mul(neg_prev_i, imag_dout);
        prev_r <= real_dout;
        prev_i <= imag_dout;
      end

      // p1: dequantized real/imag parts, held until the output pair is written
      if (state == S_SUM) begin
        x_reg_p1 <= dequantize(pr_p0) - dequantize(qi_p0);
        y_reg_p1 <= dequantize(pi_p0) + dequantize(qr_p0);
`ifdef FM_DEMOD_SKIP_FIRST_EN
        primed   <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fm_demod_prep.sv
// Testbench for fm_demod_prep.
//   The I/Q input FIFOs are modelled as queues that are read first-word-fall-
//   through. The expected x/y stream is computed as cur * conj(prev), using
//   64-bit integer division for the dequantize step.
module tb_fm_demod_prep;

  logic               clock = 1'b0;
  logic               reset;
  logic               real_rd_en, real_empty;
  logic signed [31:0] real_dout;
  logic               imag_rd_en, imag_empty;
  logic signed [31:0] imag_dout;
  logic               y_wr_en, y_full;
  logic signed [31:0] y_din;
  logic               x_wr_en, x_full;
  logic signed [31:0] x_din;

  always #5 clock = ~clock;

  fm_demod_prep dut (
    .clock      (clock),
    .reset      (reset),
    .real_rd_en (real_rd_en),
    .real_empty (real_empty),
    .real_dout  (real_dout),
    .imag_rd_en (imag_rd_en),
    .imag_empty (imag_empty),
    .imag_dout  (imag_dout),
    .y_wr_en    (y_wr_en),
    .y_full     (y_full),
    .y_din      (y_din),
    .x_wr_en    (x_wr_en),
    .x_full     (x_full),
    .x_din      (x_din)
  );

`ifdef FM_DEMOD_SKIP_FIRST_EN
  localparam int FIRST_PAIR_WRITES = 1;
  bit m_primed = 1'b0;
`else
  localparam int FIRST_PAIR_WRITES = 2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_pop = -100;
  int n_wr = 0;
  int n_pop = 0;
  int rq[$];
  int iq[$];
  int ex_q[$];
  int ey_q[$];
  bit xf = 1'b0, yf = 1'b0, hold_r = 1'b0, hold_i = 1'b0, expect_idle = 1'b0;
  int imag_lim = -1;
  int m_prev_r = 0, m_prev_i = 0;
  int last_x = 0, last_y = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint dq(input longint v);
    return v / 1024;
  endfunction

  // Queue one I/Q sample and work out the output it should produce.
  task automatic push(input int r, input int i);
    int     ni;
    longint x64, y64;
    rq.push_back(r);
    iq.push_back(i);
    ni  = -m_prev_i;
    x64 = dq(longint'(m_prev_r) * longint'(r)) - dq(longint'(ni) * longint'(i));
    y64 = dq(longint'(m_prev_r) * longint'(i)) + dq(longint'(ni) * longint'(r));
`ifdef FM_DEMOD_SKIP_FIRST_EN
    if (m_primed) begin
      ex_q.push_back(int'(x64));
      ey_q.push_back(int'(y64));
    end
    m_primed = 1'b1;
`else
    ex_q.push_back(int'(x64));
    ey_q.push_back(int'(y64));
`endif
    m_prev_r = r;
    m_prev_i = i;
  endtask

  // One clock: drive the inputs at the negedge, sample 1 ns later, and
  // update the FIFO/scoreboard models.
  task automatic cycle();
    bit re, ie;
    int ex, ey;
    re = (rq.size() == 0) || hold_r;
    ie = (iq.size() == 0) || hold_i || (imag_lim == 0);
    real_empty = re;
    imag_empty = ie;
    real_dout  = (rq.size() != 0) ? rq[0] : 32'sd0;
    imag_dout  = (iq.size() != 0) ? iq[0] : 32'sd0;
    x_full = xf;
    y_full = yf;
    #1;
    chk("rd_pair", real_rd_en, imag_rd_en);
    chk("wr_pair", x_wr_en, y_wr_en);
    if (re || ie) chk("no_pop_when_empty", real_rd_en, 1'b0);
    if (xf || yf) chk("no_write_when_full", x_wr_en, 1'b0);
    if (x_wr_en !== 1'b1) begin
      chk("x_din_zero_idle", x_din, 0);
      chk("y_din_zero_idle", y_din, 0);
    end
    if (reset || expect_idle) begin
      chk("idle_rd_en", real_rd_en, 1'b0);
      chk("idle_wr_en", x_wr_en, 1'b0);
    end
    if (real_rd_en === 1'b1 && !re && !ie) begin
      void'(rq.pop_front());
      void'(iq.pop_front());
      n_pop++;
      last_pop = cyc;
      if (imag_lim > 0) imag_lim--;
    end
    if (x_wr_en === 1'b1) begin
      n_wr++;
      chk("write_latency_ge2", (cyc - last_pop) >= 2, 1'b1);
      if (ex_q.size() == 0) begin
        chk("spurious_write", x_wr_en, 1'b0);
      end else begin
        ex = ex_q.pop_front();
        ey = ey_q.pop_front();
        chk("x_value", x_din, ex);
        chk("y_value", y_din, ey);
        last_x = x_din;
        last_y = y_din;
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while ((rq.size() != 0 || ex_q.size() != 0) && b > 0) begin
      cycle();
      b--;
    end
    chk("drain_pending_outputs", ex_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic do_reset(input int n);
    rq.delete();
    iq.delete();
    ex_q.delete();
    ey_q.delete();
    m_prev_r = 0;
    m_prev_i = 0;
`ifdef FM_DEMOD_SKIP_FIRST_EN
    m_primed = 1'b0;
`endif
    last_pop = -100;
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  function automatic int rand_sample();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 4095)) - 2048;
      2:       return 32'sh8000_0000;
      default: return int'($urandom_range(0, 2097151)) - 1048576;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p0;
    reset      = 1'b1;
    real_empty = 1'b1;
    imag_empty = 1'b1;
    real_dout  = '0;
    imag_dout  = '0;
    x_full     = 1'b0;
    y_full     = 1'b0;
    @(negedge clock);

    // Reset, then two idle cycles with empty inputs
    do_reset(2);
    expect_idle = 1'b1;
    cycle();
    cycle();
    expect_idle = 1'b0;

    // Basic pair: (1024,0),(1024,0)
    w0 = n_wr;
    push(1024, 0);
    push(1024, 0);
    drain(200);
    chk("basic_write_count", n_wr - w0, FIRST_PAIR_WRITES);
    chk("basic_x", last_x, 1024);
    chk("basic_y", last_y, 0);

    // Quarter-turn rotations
    push(0, 1024);
    drain(200);
    chk("rot1_x", last_x, 0);
    chk("rot1_y", last_y, 1024);
    push(-1024, 0);
    drain(200);
    chk("rot2_x", last_x, 0);
    chk("rot2_y", last_y, 1024);

    // Truncation toward zero
    push(1, 0);
    push(-1023, 0);
    drain(200);
    chk("trunc1_x", last_x, 0);
    chk("trunc1_y", last_y, 0);
    push(2048, 0);
    push(-1, 0);
    drain(200);
    chk("trunc2_x", last_x, -2);
    chk("trunc2_y", last_y, 0);

    // Most-negative input: the negation of prev_i wraps
    push(32'sh8000_0000, 32'sh8000_0000);
    push(32'sh8000_0000, 5);
    drain(200);
    chk("minint_x", last_x, 10485760);
    chk("minint_y", last_y, -10485760);

    // Backpressure on y only, while the FSM sits in the write phase
    yf = 1'b1;
    push(3072, 512);
    repeat (3) cycle();
    push(100, 200);
    push(-300, 400);
    p0 = n_pop;
    expect_idle = 1'b1;
    repeat (10) cycle();
    expect_idle = 1'b0;
    chk("backpressure_no_pop", n_pop - p0, 0);
    yf = 1'b0;
    w0 = n_wr;
    cycle();
    chk("release_one_write", n_wr - w0, 1);
    drain(200);

    // Input skew: I has samples, Q is held empty
    imag_lim = 0;
    push(700, -50);
    push(-900, 33);
    push(12345, 6789);
    p0 = n_pop;
    repeat (5) cycle();
    chk("skew_no_pop", n_pop - p0, 0);
    imag_lim = 1;
    p0 = n_pop;
    repeat (8) cycle();
    chk("skew_one_pop", n_pop - p0, 1);
    imag_lim = -1;
    drain(200);

    // Reset while stalled in the write phase discards the pending result
    xf = 1'b1;
    yf = 1'b1;
    push(500, -700);
    repeat (3) cycle();
    w0 = n_wr;
    expect_idle = 1'b1;
    do_reset(1);
    cycle();
    expect_idle = 1'b0;
    chk("reset_discard", n_wr - w0, 0);
    xf = 1'b0;
    yf = 1'b0;
    w0 = n_wr;
    push(1024, 0);
    push(1024, 0);
    drain(200);
    chk("post_reset_write_count", n_wr - w0, FIRST_PAIR_WRITES);
    chk("post_reset_x", last_x, 1024);
    chk("post_reset_y", last_y, 0);

    // Random samples with random stalls on every handshake
    repeat (150) begin
      push(rand_sample(), rand_sample());
      xf     = ($urandom_range(0, 3) == 0);
      yf     = ($urandom_range(0, 3) == 0);
      hold_r = ($urandom_range(0, 3) == 0);
      hold_i = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 4)) cycle();
    end
    xf     = 1'b0;
    yf     = 1'b0;
    hold_r = 1'b0;
    hold_i = 1'b0;
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
